// File: rtl/xiangwei_leijiaqi.sv
// DDS phase accumulator: frequency-word integration, phase offset, ROM addresses, square/triangle synthesis.
// Optional phase dither is enabled by defining XIANGWEI_DOUDONG_EN.
module xiangwei_leijiaqi #(
    parameter int unsigned          ACC_W    = 32,
    parameter logic [ACC_W-1:0]     FCW_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ACC_W-1:0] pinlv,
    input  logic             pinlv_vld,
    output logic             pinlv_rdy,
    input  logic [9:0]       xiangwei,
    input  logic [9:0]       zhankongbi,
    output logic [9:0]       dizhi_sin,
    output logic [9:0]       dizhi_cos,
    output logic [9:0]       fangbo,
    output logic [9:0]       sanjiaobo,
    output logic             guoling
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] fcw_act_q, pend_q;
    logic             carry_d;
    logic             wrap_q;
    logic             rdy_q;
    logic             guoling_q;
    logic [9:0]       sin_q, cos_q, fang_q, tri_q;
    logic [9:0]       p_d, tri_d;

    assign {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, fcw_act_q};

`ifdef XIANGWEI_DOUDONG_EN
    localparam int unsigned LW = ACC_W - 10;
    localparam int unsigned DW = (LW < 16) ? LW : 16;

    logic [15:0] lfsr_q;
    logic [LW:0] dsum_d;

    // Dither only nudges the truncation; its carry reaches p, never acc.
    assign dsum_d = {1'b0, acc_q[LW-1:0]} + (LW+1)'(lfsr_q[DW-1:0]);
    assign p_d    = acc_q[ACC_W-1 -: 10] + xiangwei + {9'b0, dsum_d[LW]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else if (en) begin
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end
    end
`else
    assign p_d = acc_q[ACC_W-1 -: 10] + xiangwei;
`endif

    assign tri_d = p_d[9] ? ~{p_d[8:0], 1'b0} : {p_d[8:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            fcw_act_q <= FCW_INIT;
            pend_q    <= '0;
            wrap_q    <= 1'b0;
            rdy_q     <= 1'b1;
            guoling_q <= 1'b0;
            sin_q     <= '0;
            cos_q     <= '0;
            fang_q    <= '0;
            tri_q     <= '0;
        end else begin
            // wrap_q delays the carry so guoling lines up with the post-wrap outputs.
            if (en) begin
                acc_q     <= acc_d;
                wrap_q    <= carry_d;
                guoling_q <= wrap_q;
                sin_q     <= p_d;
                cos_q     <= p_d + 10'd256;
                fang_q    <= (p_d < zhankongbi) ? '1 : '0;
                tri_q     <= tri_d;
            end else begin
                guoling_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (pinlv_vld) begin
                        pend_q  <= pinlv;
                        state_q <= PEND;
                        rdy_q   <= 1'b0;
                    end
                end
                PEND: begin
                    // A zero word can never wrap, so it is replaced immediately.
                    if ((fcw_act_q == '0) || (en && carry_d)) begin
                        fcw_act_q <= pend_q;
                        state_q   <= IDLE;
                        rdy_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign pinlv_rdy = rdy_q;
    assign guoling   = guoling_q;
    assign dizhi_sin = sin_q;
    assign dizhi_cos = cos_q;
    assign fangbo    = fang_q;
    assign sanjiaobo = tri_q;

endmodule
